ff_share_pipe: RTL and testbench

- Parametrised elastic pipeline register for masked operands: NS shares of NB bits each, DEPTH stages, valid/ready handshake at both ends.
- Generalises the single-enable flip-flop used in the masked ALU and B2A paths with bubble collapsing, back-pressure and flush.
- Adds zeroisation of idle stages so that no stale share value stays in a register once it has left the pipeline.
- Sits between masked ALU sub-units, for example between B2A conversion stages, wherever share transport must be stallable.

---
 rtl/ff_share_pipe_if.sv | 21 ++
 rtl/ff_share_pipe.sv | 90 +++++++++
 tb/tb_ff_share_pipe.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ff_share_pipe_if.sv
// ff_share_pipe_if: handshake bundle for the masked share pipeline.
//   in_valid/in_ready/in_data    : producer -> pipeline beat
//   out_valid/out_ready/out_data : pipeline -> consumer beat
// Share k of a beat occupies bits [k*NB +: NB].
// master = environment side (producer + consumer), slave = pipeline side.
interface ff_share_pipe_if #(
  parameter int NB = 32,
  parameter int NS = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [NS*NB-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [NS*NB-1:0] out_data;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/ff_share_pipe.sv
// ff_share_pipe: elastic DEPTH-stage register pipeline for NS masked shares of
// NB bits. Bubbles collapse, back-pressure stalls every full stage, flush and
// reset clear all state. With CLR_IDLE=1 a stage that empties is zeroised so
// no share value lingers once it has left the pipeline.
// Ports:
//   g_clk      clock (posedge)
//   g_resetn   synchronous active-low reset
//   flush      synchronous flush, same effect as reset
//   bus        in/out valid-ready handshake (ff_share_pipe_if.slave)
//   occupancy  number of valid stages
//   busy       any stage valid
module ff_share_pipe #(
  parameter int NB       = 32,
  parameter int NS       = 2,
  parameter int DEPTH    = 3,
  parameter bit CLR_IDLE = 1'b1
) (
  input  logic                       g_clk,
  input  logic                       g_resetn,
  input  logic                       flush,
  ff_share_pipe_if.slave             bus,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       busy
);
  localparam int OW = $clog2(DEPTH+1);

  // Shares are kept as separate NB-bit fields; each is only a mux plus a
  // register, nothing ever mixes bits of different shares.
  logic [DEPTH-1:0]                  v_q, v_d;
  logic [DEPTH-1:0][NS-1:0][NB-1:0]  data_q, data_d;
  logic [DEPTH-1:0]                  adv, load;
  logic [NS-1:0][NB-1:0]             in_shares;

  assign in_shares = bus.in_data;

  // adv[i] = v[i] & (!v[i+1] | adv[i+1]) unrolled: a stage moves when some
  // stage above it is empty or the whole run above it drains via out_ready.
  // Written with a running AND so no signal feeds back into itself.
  always_comb begin
    logic full_above;
    full_above = 1'b1;
    adv        = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      adv[i]     = v_q[i] & (!full_above | bus.out_ready);
      full_above = full_above & v_q[i];
    end
  end

  assign bus.in_ready = g_resetn & !flush & (!v_q[0] | adv[0]);

  always_comb begin
    load    = '0;
    load[0] = bus.in_valid & bus.in_ready;
    for (int i = 1; i < DEPTH; i++) load[i] = adv[i-1];
  end

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    for (int i = 0; i < DEPTH; i++) begin
      v_d[i] = load[i] | (v_q[i] & !adv[i]);
      if (load[i]) begin
        data_d[i] = (i == 0) ? in_shares : data_q[(i == 0) ? 0 : i-1];
      end else if (CLR_IDLE && adv[i]) begin
        // Stage vacated with nothing following: wipe the stale shares.
        data_d[i] = '0;
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn || flush) begin
      v_q    <= '0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  assign bus.out_valid = v_q[DEPTH-1];
  assign bus.out_data  = data_q[DEPTH-1];

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OW'(v_q[i]);
  end

  assign busy = |v_q;
endmodule

// File: tb/tb_ff_share_pipe.sv
module tb_ff_share_pipe;
  localparam int NB = 8, NS = 2, DEPTH = 3;

  logic        g_clk = 1'b0;
  logic        g_resetn, flush, in_valid, out_ready;
  logic [15:0] in_data;
  logic [1:0]  occ0, occ1;
  logic        busy0, busy1;
  int          n_cmp = 0, n_err = 0;

  always #5 g_clk = ~g_clk;

  ff_share_pipe_if #(.NB(NB), .NS(NS)) b0 ();
  ff_share_pipe_if #(.NB(NB), .NS(NS)) b1 ();
  assign b0.in_valid  = in_valid;
  assign b0.in_data   = in_data;
  assign b0.out_ready = out_ready;
  assign b1.in_valid  = in_valid;
  assign b1.in_data   = in_data;
  assign b1.out_ready = out_ready;

  ff_share_pipe #(.NB(NB), .NS(NS), .DEPTH(DEPTH), .CLR_IDLE(1'b1)) u0 (
    .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush), .bus(b0),
    .occupancy(occ0), .busy(busy0));
  ff_share_pipe #(.NB(NB), .NS(NS), .DEPTH(DEPTH), .CLR_IDLE(1'b0)) u1 (
    .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush), .bus(b1),
    .occupancy(occ1), .busy(busy1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d);
    in_valid = v;
    in_data  = d;
    #1;
  endtask

  logic [15:0] q[$];
  logic [15:0] beats[100];
  int          sent;
  logic        acc;

  initial begin
    g_resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    tick(); tick();
    // reset state
    chk("rst_in_ready", b0.in_ready, 1'b0);
    chk("rst_out_valid", b0.out_valid, 1'b0);
    chk("rst_out_data", b0.out_data, 16'h0);
    chk("rst_occ", occ0, 2'd0);
    chk("rst_busy", busy0, 1'b0);
    g_resetn = 1'b1;
    tick();

    // single beat, latency DEPTH-1 then exit with zeroisation
    out_ready = 1'b1;
    drive(1'b1, 16'h5AA5);
    chk("t1_in_ready", b0.in_ready, 1'b1);
    tick();
    drive(1'b0, 16'hFFFF);
    chk("t1_occ_a", occ0, 2'd1);
    chk("t1_ov_a", b0.out_valid, 1'b0);
    chk("t1_busy", busy0, 1'b1);
    tick();
    chk("t1_occ_b", occ0, 2'd1);
    chk("t1_ov_b", b0.out_valid, 1'b0);
    chk("t1_s0_zero", u0.data_q[0], 16'h0);
    tick();
    chk("t1_ov_c", b0.out_valid, 1'b1);
    chk("t1_data", b0.out_data, 16'h5AA5);
    chk("t1_occ_c", occ0, 2'd1);
    tick();
    chk("t1_occ_d", occ0, 2'd0);
    chk("t1_ov_d", b0.out_valid, 1'b0);
    chk("t1_od_zero", b0.out_data, 16'h0);
    chk("t1_regs_zero", u0.data_q, 48'h0);
    chk("t1_keep_od", b1.out_data, 16'h5AA5);
    chk("t1_keep_ov", b1.out_valid, 1'b0);

    // stall: 3 accepted, 4th waits until first pop
    out_ready = 1'b0;
    drive(1'b1, 16'h0101); tick();
    drive(1'b1, 16'h0202); tick();
    drive(1'b1, 16'h0303); tick();
    drive(1'b1, 16'h0404);
    chk("t2_occ_full", occ0, 2'd3);
    chk("t2_in_ready_full", b0.in_ready, 1'b0);
    chk("t2_head", b0.out_data, 16'h0101);
    tick();
    chk("t2_hold_data", b0.out_data, 16'h0101);
    chk("t2_hold_occ", occ0, 2'd3);
    out_ready = 1'b1;
    #1;
    chk("t2_push_pop_ready", b0.in_ready, 1'b1);
    tick();
    drive(1'b0, 16'h0);
    chk("t2_occ_same", occ0, 2'd3);
    chk("t2_d2", b0.out_data, 16'h0202);
    tick();
    chk("t2_d3", b0.out_data, 16'h0303);
    chk("t2_occ2", occ0, 2'd2);
    tick();
    chk("t2_d4", b0.out_data, 16'h0404);
    chk("t2_occ1", occ0, 2'd1);
    tick();
    chk("t2_empty", b0.out_valid, 1'b0);
    chk("t2_occ0", occ0, 2'd0);

    // bubble collapse
    out_ready = 1'b0;
    drive(1'b1, 16'h1111); tick();
    drive(1'b0, 16'h0);    tick();
    drive(1'b1, 16'h2222); tick();
    drive(1'b0, 16'h0);    tick();
    chk("t3_occ", occ0, 2'd2);
    chk("t3_s2", b0.out_data, 16'h1111);
    chk("t3_s1", u0.data_q[1], 16'h2222);
    chk("t3_s0", u0.data_q[0], 16'h0);
    out_ready = 1'b1;
    tick();
    chk("t3_next", b0.out_data, 16'h2222);
    tick();
    chk("t3_drained", occ0, 2'd0);

    // streaming scoreboard, 100 random beats
    for (int i = 0; i < 100; i++) beats[i] = 16'($urandom);
    sent = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 130; cyc++) begin
      if (sent == 100 && q.size() == 0) break;
      if (sent < 100) drive(1'b1, beats[sent]); else drive(1'b0, 16'h0);
      acc = in_valid & b0.in_ready;
      if (b0.out_valid) begin
        if (q.size() == 0) chk("sb_spurious", 1'b1, 1'b0);
        else chk("sb_data", b0.out_data, q.pop_front());
      end
      if (sent < 100) begin
        chk("sb_thru", b0.in_ready, 1'b1);
        if (cyc >= 3) chk("sb_occ", occ0, 2'd3);
      end
      if (acc) begin
        q.push_back(in_data);
        sent++;
      end
      tick();
    end
    chk("sb_sent", sent, 100);
    chk("sb_left", q.size(), 0);
    drive(1'b0, 16'h0);

    // flush with 3 in flight and a beat offered
    out_ready = 1'b0;
    drive(1'b1, 16'h0A0A); tick();
    drive(1'b1, 16'h0B0B); tick();
    drive(1'b1, 16'h0C0C); tick();
    flush = 1'b1;
    drive(1'b1, 16'h0D0D);
    chk("t5_pre_occ", occ0, 2'd3);
    chk("t5_in_ready", b0.in_ready, 1'b0);
    tick();
    flush = 1'b0;
    drive(1'b0, 16'h0);
    chk("t5_occ", occ0, 2'd0);
    chk("t5_ov", b0.out_valid, 1'b0);
    chk("t5_regs0", u0.data_q, 48'h0);
    chk("t5_regs1", u1.data_q, 48'h0);
    tick();
    chk("t5_dropped", occ0, 2'd0);

    // reset mid-stream
    out_ready = 1'b1;
    drive(1'b1, 16'h3131); tick();
    drive(1'b1, 16'h3232); tick();
    g_resetn = 1'b0;
    drive(1'b1, 16'h3333);
    chk("t6_rst_ready", b0.in_ready, 1'b0);
    tick();
    g_resetn = 1'b1;
    drive(1'b0, 16'h0);
    chk("t6_occ", occ0, 2'd0);
    chk("t6_od0", b0.out_data, 16'h0);
    chk("t6_od1", b1.out_data, 16'h0);
    chk("t6_regs1", u1.data_q, 48'h0);
    tick();
    chk("t6_no_partial", b0.out_valid | b1.out_valid, 1'b0);

    // CLR_IDLE=0 keeps vacated data, CLR_IDLE=1 wipes it
    out_ready = 1'b0;
    drive(1'b1, 16'h4141); tick();
    drive(1'b1, 16'h4242); tick();
    drive(1'b0, 16'h0);    tick();
    out_ready = 1'b1;
    tick();
    chk("t7_keep_s1", u1.data_q[1], 16'h4242);
    chk("t7_wipe_s1", u0.data_q[1], 16'h0);
    chk("t7_occ1", occ1, 2'd1);
    tick();
    chk("t7_ov1", b1.out_valid, 1'b0);
    chk("t7_od1_kept", b1.out_data, 16'h4242);
    chk("t7_occ1_0", occ1, 2'd0);
    chk("t7_busy1", busy1, 1'b0);
    chk("t7_od0_zero", b0.out_data, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
